log2_burst_buf: RTL and testbench
=================================

Name: log2_burst_buf

Overview:
- Parametrised successor to the team's 8-bit burst log2 unit.
- Accepts a contiguous burst of unsigned samples and computes floor or ceil log2 of each sample on entry.
- Buffers up to DEPTH results, then replays them in arrival order on a valid/ready output stream once the burst ends.
- Sits between the sample front-end and downstream scaling/normalisation logic.

Parameters:
DATA_W, 8, input sample width in bits (>=2)
DEPTH, 6, result buffer entries per burst (>=1)
OUT_W, derived localparam = $clog2(DATA_W+1), result width; not user-overridable

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
in_data  input  DATA_W  unsigned sample
in_valid  input  1  sample valid; a burst is a run of consecutive in_valid=1 cycles
in_ready  output  1  block accepting samples (IDLE or COLLECT)
ceil_mode  input  1  1=ceil(log2), 0=floor(log2); latched on first beat of burst
out_data  output  OUT_W  log2 result
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  marks final result of burst (qualified by out_valid)
overflow  output  1  sticky: current/last burst exceeded DEPTH; cleared at next burst start
busy  output  1  high in COLLECT or DRAIN

Behaviour:
- Reset (async assert, sync release): state=IDLE, wr/rd pointers=0, out_valid=0, out_last=0, out_data=0, overflow=0, busy=0, in_ready=1; buffer contents undefined, never read before written.
- Arithmetic, x = in_data:
  - floor(x) = index of MSB set; x=0 -> 0, x=1 -> 0.
  - ceil(x) = floor(x) + (x not power of 2); x=0 -> 0, x=1 -> 0.
  - Maximum result is DATA_W (ceil of 2^DATA_W-1), so it fits in OUT_W.
  - Result is computed combinationally at write time and stored in the buffer.
- FSM IDLE -> COLLECT -> DRAIN -> IDLE:
  - IDLE, in_valid=1 at an edge: store result at entry 0; cnt=1; latch ceil_mode; clear overflow; go COLLECT.
  - COLLECT, in_valid=1, cnt<DEPTH: store at entry cnt; cnt+1.
  - COLLECT, in_valid=1, cnt==DEPTH: sample discarded; overflow<=1; cnt unchanged.
  - COLLECT, in_valid=0 at an edge: go DRAIN; same edge sets out_valid=1, out_data=entry 0, out_last=(cnt==1); rd=1.
  - Latency: out_valid rises on the first edge where in_valid is sampled low.
  - DRAIN: in_ready=0; in_valid and in_data ignored (no storage, no overflow effect).
  - DRAIN, out_valid & out_ready at an edge with !out_last: present the next entry (out_data=entry rd, rd+1, out_last when rd==cnt-1).
  - DRAIN, out_valid & out_ready with out_last: out_valid<=0, out_last<=0, go IDLE.
  - Back-to-back bursts: a new burst is accepted the cycle after returning to IDLE.
  - DRAIN, out_valid & !out_ready: out_data and out_last held stable; no advance.
- Outputs are registered; out_data never changes while out_valid=1 && out_ready=0.
- ceil_mode changes mid-burst have no effect until the next burst start.
- busy = (state != IDLE); in_ready = (state != DRAIN).
- overflow stays high through DRAIN and IDLE until the next burst's first beat.
- Reset mid-COLLECT or mid-DRAIN: immediate return to reset values; the partial burst is lost; no out_valid afterwards until a new complete burst.

Test Plan:
- Ceil burst, DATA_W=8, DEPTH=6: ceil_mode=1, in_data 1,2,5,128,255 on 5 consecutive cycles, then in_valid=0 -> out_valid rises the cycle after the drop; outputs 0,1,3,7,8 with out_ready=1; out_last on 8; overflow=0.
- Floor burst: ceil_mode=0, same data -> 0,1,2,7,7; ceil_mode toggled mid-burst -> results unchanged.
- Overflow: 8 beats of x=16 with DEPTH=6 -> exactly 6 outputs of 4; overflow=1 until the next burst's first beat, then 0.
- Backpressure: 3-beat burst; out_ready pattern 0,0,1,0,1,1 -> each out_data held while stalled; 3 results in order; single out_last.
- Ignore during drain: in_valid=1 with x=3 during DRAIN -> in_ready=0; output sequence unaffected; return to IDLE afterwards.
- Edge values: single-beat bursts x=0 -> 0; x=1 -> 0 with out_last=1 on the same cycle.
- Reset mid-DRAIN (after 2 of 5 outputs) -> out_valid=0, busy=0, overflow=0 immediately; a fresh 1-beat burst x=4 -> output 2.

Source files
------------

// File: rtl/log2_burst_buf_if.sv
// Sample-in / result-out stream bundle for the burst log2 buffer.
// master drives samples and accepts results; slave is the buffer.
interface log2_burst_buf_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned OUT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/log2_burst_buf.sv
// Burst log2 unit: computes floor/ceil log2 per sample on entry, buffers up to
// DEPTH results, then replays them in order on a valid/ready stream.
module log2_burst_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    log2_burst_buf_if.slave      bus,
    input  logic                 ceil_mode_i,
    output logic                 overflow_o,
    output logic                 busy_o
);
    localparam int unsigned OUT_W  = $clog2(DATA_W + 1);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rd_q, rd_d;
    logic               mode_q, mode_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   mem_q [DEPTH];

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_mode;
    logic [OUT_W-1:0]   wr_data;

    // MSB index, bumped by one for non-powers of two in ceil mode (0 and 1 map to 0)
    function automatic logic [OUT_W-1:0] log2_f(input logic [DATA_W-1:0] x, input logic up);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (x[i]) r = OUT_W'(i);
        end
        if (up && ((x & (x - DATA_W'(1))) != '0)) r = r + OUT_W'(1);
        return r;
    endfunction

    assign wr_data = log2_f(bus.in_data, wr_mode);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        wr_en       = 1'b0;
        wr_addr     = ADDR_W'(cnt_q);
        wr_mode     = mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_mode = ceil_mode_i;
                    mode_d  = ceil_mode_i;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    if (cnt_q < CNT_W'(DEPTH)) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d     = ST_DRAIN;
                    out_valid_d = 1'b1;
                    out_data_d  = mem_q[0];
                    out_last_d  = (cnt_q == CNT_W'(1));
                    rd_d        = CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        out_data_d = mem_q[ADDR_W'(rd_q)];
                        out_last_d = (rd_q == cnt_q - CNT_W'(1));
                        rd_d       = rd_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Result storage has no reset: entries are always written before being read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.in_ready  = in_ready_q;
    assign overflow_o    = ovf_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_log2_burst_buf.sv
// Scoreboard bench for log2_burst_buf: expected results queued at drive time,
// popped and compared on each output handshake.
module tb_log2_burst_buf;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ceil_mode = 1'b0;
    logic overflow;
    logic busy;

    log2_burst_buf_if #(.DATA_W(DATA_W)) bus ();

    log2_burst_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ceil_mode_i(ceil_mode),
        .overflow_o (overflow),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int sb_data[$];
    int sb_last[$];
    int bd[8];
    int rp[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference log2 by repeated doubling
    function automatic int model_log2(input int x, input bit up);
        int r;
        r = 0;
        if (x <= 1) return 0;
        if (up) begin
            while ((1 << r) < x) r++;
        end else begin
            while ((1 << (r + 1)) <= x) r++;
        end
        return r;
    endfunction

    // Output monitor: pops on handshake, checks stability while stalled
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid) begin
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
                check("hold_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_data.size() == 0) begin
                    check("unexpected_out", 32'(1), 32'(0));
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(sb_data.pop_front()));
                    check("out_last", 32'(bus.out_last), 32'(sb_last.pop_front()));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // Drive n beats from bd[]; optionally flip ceil_mode on every later beat
    task automatic burst(input int n, input bit mode, input bit toggle);
        int k;
        k = (n < int'(DEPTH)) ? n : int'(DEPTH);
        for (int i = 0; i < n; i++) begin
            check("in_ready_collect", 32'(bus.in_ready), 32'(1));
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(bd[i]);
            ceil_mode    = (toggle && (i % 2 == 1)) ? ~mode : mode;
            if (i < k) begin
                sb_data.push_back(model_log2(bd[i], mode));
                sb_last.push_back((i == k - 1) ? 1 : 0);
            end
            @(posedge clk); #1;
            check("overflow_collect", 32'(overflow), 32'((i >= int'(DEPTH)) ? 1 : 0));
            check("busy_collect", 32'(busy), 32'(1));
        end
        bus.in_valid = 1'b0;
        ceil_mode    = ~mode;
        check("no_early_valid", 32'(bus.out_valid), 32'(0));
        @(posedge clk); #1;
        check("valid_latency", 32'(bus.out_valid), 32'(1));
        check("in_ready_drain", 32'(bus.in_ready), 32'(0));
        check("busy_drain", 32'(busy), 32'(1));
    endtask

    // Run out the drain using rp[] as the out_ready pattern, then all-ready
    task automatic drain(input int plen, input bit poke, input bit exp_ovf);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.out_ready = (c < plen) ? rp[c][0] : 1'b1;
            if (poke) begin
                bus.in_valid = bus.out_valid;
                bus.in_data  = DATA_W'(3);
                if (bus.out_valid) check("in_ready_poke", 32'(bus.in_ready), 32'(0));
            end
            @(posedge clk); #1;
            if (sb_data.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("drain_done", 32'(done), 32'(1));
        check("sb_empty", 32'(sb_data.size()), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_in_ready", 32'(bus.in_ready), 32'(1));
        check("idle_overflow", 32'(overflow), 32'(exp_ovf));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_last", 32'(bus.out_last), 32'(0));
        check("rst_out_data", 32'(bus.out_data), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ceil burst: 0,1,3,7,8
        bd = '{1, 2, 5, 128, 255, 0, 0, 0};
        burst(5, 1'b1, 1'b0);
        drain(0, 1'b0, 1'b0);

        // floor burst with ceil_mode toggling mid-burst: 0,1,2,7,7
        burst(5, 1'b0, 1'b1);
        drain(0, 1'b0, 1'b0);

        // overflow: 8 beats of 16 -> six 4s
        bd = '{16, 16, 16, 16, 16, 16, 16, 16};
        burst(8, 1'b0, 1'b0);
        drain(0, 1'b0, 1'b1);
        check("ovf_sticky_idle", 32'(overflow), 32'(1));

        // backpressure on a 3-beat burst; also clears overflow on first beat
        bd = '{3, 100, 64, 0, 0, 0, 0, 0};
        rp = '{0, 0, 1, 0, 1, 1, 1, 1};
        burst(3, 1'b1, 1'b0);
        drain(6, 1'b0, 1'b0);

        // input activity during drain is ignored
        bd = '{7, 9, 200, 0, 0, 0, 0, 0};
        rp = '{0, 1, 0, 1, 1, 1, 1, 1};
        burst(3, 1'b0, 1'b0);
        drain(4, 1'b1, 1'b0);

        // single-beat edge values
        bd = '{0, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 1'b1, 1'b0);
        drain(0, 1'b0, 1'b0);
        bd = '{1, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 1'b1, 1'b0);
        drain(0, 1'b0, 1'b0);
        bd = '{255, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 1'b1, 1'b0);
        drain(0, 1'b0, 1'b0);

        // reset mid-drain after 2 of 5 outputs
        bd = '{1, 2, 5, 128, 255, 0, 0, 0};
        burst(5, 1'b1, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("pre_rst_remaining", 32'(sb_data.size()), 32'(3));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_overflow", 32'(overflow), 32'(0));
        check("midrst_in_ready", 32'(bus.in_ready), 32'(1));
        sb_data.delete();
        sb_last.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", 32'(bus.out_valid), 32'(0));
        end
        bus.out_ready = 1'b0;
        bd = '{4, 0, 0, 0, 0, 0, 0, 0};
        burst(1, 1'b0, 1'b0);
        drain(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
